fmul_pipe: RTL and testbench

- Parametrised, pipelined floating-point multiplier; next generation of the single-cycle fmul in the FPU.
- Adds configurable format and latency, a valid/ready handshake with backpressure, selectable rounding, IEEE special-value handling and exception flags.
- Sits between the FPU issue stage and the writeback arbiter.
- Default parameters give binary32.

---
 rtl/fmul_pipe_if.sv | 23 ++
 rtl/fmul_pipe.sv | 185 ++++++++++++++++++
 tb/tb_fmul_pipe.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/fmul_pipe_if.sv
// Operand/result handshake bundle for fmul_pipe: issue side drives operands,
// writeback side supplies out_ready.
interface fmul_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x1;
    logic [W-1:0] x2;
    logic         rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic [2:0]   flags;

    modport master (output in_valid, x1, x2, rm, out_ready,
                    input  in_ready, out_valid, y, flags);
    modport slave  (input  in_valid, x1, x2, rm, out_ready,
                    output in_ready, out_valid, y, flags);
endinterface

// File: rtl/fmul_pipe.sv
// Pipelined IEEE-style multiplier (flush-to-zero in and out) with global-stall
// valid/ready handshake; product -> normalise/round -> specials/pack.
module fmul_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 3
) (
    input  logic       clk,
    input  logic       rst,
    fmul_pipe_if.slave bus
);
    localparam int W = EXP_W + MAN_W + 1;

    typedef logic signed [EXP_W+1:0] exp_t;
    localparam exp_t BIAS_E = exp_t'((1 << (EXP_W-1)) - 1);
    localparam exp_t EMAX_E = exp_t'((1 << EXP_W) - 1);

    typedef struct packed {
        logic                 sy;
        logic                 nv;
        logic                 inf;
        logic                 zero;
        logic                 rm;
        exp_t                 esum;
        logic [2*MAN_W+1:0]   p;
    } prod_t;

    typedef struct packed {
        logic                 sy;
        logic                 nv;
        logic                 inf;
        logic                 zero;
        exp_t                 e;
        logic [MAN_W-1:0]     m;
    } norm_t;

    typedef struct packed {
        logic [W-1:0] y;
        logic [2:0]   flags;
    } res_t;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("fmul_pipe: STAGES must be in 1..4");
    end

    function automatic prod_t f_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic rnd);
        prod_t              r;
        logic               amax, bmax, za, zb, na, nb, ia, ib;
        logic [2*MAN_W+1:0] ma, mb;
        amax   = &a[W-2:MAN_W];
        bmax   = &b[W-2:MAN_W];
        za     = ~|a[W-2:MAN_W];
        zb     = ~|b[W-2:MAN_W];
        na     = amax & (|a[MAN_W-1:0]);
        nb     = bmax & (|b[MAN_W-1:0]);
        ia     = amax & ~(|a[MAN_W-1:0]);
        ib     = bmax & ~(|b[MAN_W-1:0]);
        r.sy   = a[W-1] ^ b[W-1];
        r.nv   = na | nb | (ia & zb) | (ib & za);
        r.inf  = ia | ib;
        r.zero = za | zb;
        r.rm   = rnd;
        r.esum = exp_t'({2'b00, a[W-2:MAN_W]}) + exp_t'({2'b00, b[W-2:MAN_W]}) - BIAS_E;
        ma     = {{(MAN_W+1){1'b0}}, 1'b1, a[MAN_W-1:0]};
        mb     = {{(MAN_W+1){1'b0}}, 1'b1, b[MAN_W-1:0]};
        r.p    = ma * mb;
        return r;
    endfunction

    function automatic norm_t f_norm(input prod_t p);
        norm_t            r;
        logic             a, g, st, inc;
        logic [MAN_W-1:0] m;
        logic [MAN_W:0]   mr;
        a = p.p[2*MAN_W+1];
        if (a) begin
            m  = p.p[2*MAN_W:MAN_W+1];
            g  = p.p[MAN_W];
            st = |p.p[MAN_W-1:0];
        end else begin
            m  = p.p[2*MAN_W-1:MAN_W];
            g  = p.p[MAN_W-1];
            st = |p.p[MAN_W-2:0];
        end
        inc    = ~p.rm & g & (st | m[0]);
        mr     = {1'b0, m} + {{MAN_W{1'b0}}, inc};
        r.sy   = p.sy;
        r.nv   = p.nv;
        r.inf  = p.inf;
        r.zero = p.zero;
        // A rounding carry leaves mr[MAN_W-1:0] at zero, which is the wrapped mantissa.
        r.e    = p.esum + exp_t'({{(EXP_W+1){1'b0}}, a})
                        + exp_t'({{(EXP_W+1){1'b0}}, mr[MAN_W]});
        r.m    = mr[MAN_W-1:0];
        return r;
    endfunction

    function automatic res_t f_pack(input norm_t n);
        res_t r;
        r.flags = 3'b000;
        if (n.nv) begin
            r.y     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            r.flags = 3'b100;
        end else if (n.inf) begin
            r.y = {n.sy, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (n.zero) begin
            r.y = {n.sy, {(W-1){1'b0}}};
        end else if (n.e >= EMAX_E) begin
            r.y     = {n.sy, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r.flags = 3'b010;
        end else if (n.e <= exp_t'(0)) begin
            r.y     = {n.sy, {(W-1){1'b0}}};
            r.flags = 3'b001;
        end else begin
            r.y = {n.sy, n.e[EXP_W-1:0], n.m};
        end
        return r;
    endfunction

    logic          w_adv;
    logic [STAGES:1] r_vld_pipe;
    res_t          w_last;

    assign w_adv        = bus.out_ready | ~r_vld_pipe[STAGES];
    assign bus.in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe <= '0;
        end else if (w_adv) begin
            r_vld_pipe[1] <= bus.in_valid;
            for (int i = 2; i <= STAGES; i++) r_vld_pipe[i] <= r_vld_pipe[i-1];
        end
    end

    if (STAGES == 1) begin : g_s1
        res_t r_o;
        always_ff @(posedge clk) begin
            if (rst)        r_o <= '0;
            else if (w_adv) r_o <= f_pack(f_norm(f_prod(bus.x1, bus.x2, bus.rm)));
        end
        assign w_last = r_o;
    end else begin : g_sn
        prod_t r_p;
        always_ff @(posedge clk) begin
            if (rst)        r_p <= '0;
            else if (w_adv) r_p <= f_prod(bus.x1, bus.x2, bus.rm);
        end
        if (STAGES == 2) begin : g_s2
            res_t r_o;
            always_ff @(posedge clk) begin
                if (rst)        r_o <= '0;
                else if (w_adv) r_o <= f_pack(f_norm(r_p));
            end
            assign w_last = r_o;
        end else begin : g_s3
            norm_t r_n;
            res_t  r_o;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_n <= '0;
                    r_o <= '0;
                end else if (w_adv) begin
                    r_n <= f_norm(r_p);
                    r_o <= f_pack(r_n);
                end
            end
            if (STAGES == 4) begin : g_s4
                res_t r_d;
                always_ff @(posedge clk) begin
                    if (rst)        r_d <= '0;
                    else if (w_adv) r_d <= r_o;
                end
                assign w_last = r_d;
            end else begin : g_s3o
                assign w_last = r_o;
            end
        end
    end

    assign bus.out_valid = r_vld_pipe[STAGES];
    assign bus.y         = w_last.y;
    assign bus.flags     = w_last.flags;
endmodule

// File: tb/tb_fmul_pipe.sv
// Directed bench for fmul_pipe: binary32 main instance plus latency/format sweep instances.
module tb_fmul_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    fmul_pipe_if #(.EXP_W(8),  .MAN_W(23)) bm ();
    fmul_pipe_if #(.EXP_W(8),  .MAN_W(23)) b1 ();
    fmul_pipe_if #(.EXP_W(8),  .MAN_W(23)) b2 ();
    fmul_pipe_if #(.EXP_W(8),  .MAN_W(23)) b4 ();
    fmul_pipe_if #(.EXP_W(11), .MAN_W(52)) bd ();

    fmul_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(3)) u_m  (.clk(clk), .rst(rst), .bus(bm));
    fmul_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .bus(b1));
    fmul_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .bus(b2));
    fmul_pipe #(.EXP_W(8),  .MAN_W(23), .STAGES(4)) u_s4 (.clk(clk), .rst(rst), .bus(b4));
    fmul_pipe #(.EXP_W(11), .MAN_W(52), .STAGES(3)) u_d  (.clk(clk), .rst(rst), .bus(bd));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic r, input logic [31:0] ey, input logic [2:0] ef);
        bm.x1 = a; bm.x2 = b; bm.rm = r; bm.in_valid = 1'b1; bm.out_ready = 1'b1;
        tick();
        bm.in_valid = 1'b0;
        for (int i = 0; i < 8 && !bm.out_valid; i++) tick();
        chk({tag, " valid"}, 64'(bm.out_valid), 64'd1);
        chk({tag, " y"},     64'(bm.y),         64'(ey));
        chk({tag, " flags"}, 64'(bm.flags),     64'(ef));
        tick();
    endtask

    logic [31:0] tab  [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [31:0] expv [6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                              32'h41000000, 32'h41200000, 32'h41400000};

    initial begin
        int          lm, l1, l2, l4, ld, sent, rcv;
        logic [31:0] ym, y1, y2, y4;
        logic [63:0] yd;
        logic        seen;

        bm.in_valid = 0; bm.x1 = '0; bm.x2 = '0; bm.rm = 0; bm.out_ready = 0;
        b1.in_valid = 0; b1.x1 = '0; b1.x2 = '0; b1.rm = 0; b1.out_ready = 1;
        b2.in_valid = 0; b2.x1 = '0; b2.x2 = '0; b2.rm = 0; b2.out_ready = 1;
        b4.in_valid = 0; b4.x1 = '0; b4.x2 = '0; b4.rm = 0; b4.out_ready = 1;
        bd.in_valid = 0; bd.x1 = '0; bd.x2 = '0; bd.rm = 0; bd.out_ready = 1;

        rst = 1'b1;
        tick(); tick();
        chk("reset out_valid", 64'(bm.out_valid), 64'd0);
        chk("reset y",         64'(bm.y),         64'd0);
        chk("reset flags",     64'(bm.flags),     64'd0);
        chk("reset in_ready",  64'(bm.in_ready),  64'd1);
        rst = 1'b0;
        bm.out_ready = 1'b1;

        // 1.5 * 2.0 on every depth, plus the binary64 instance
        bm.x1 = 32'h3FC00000; bm.x2 = 32'h40000000; bm.in_valid = 1;
        b1.x1 = 32'h3FC00000; b1.x2 = 32'h40000000; b1.in_valid = 1;
        b2.x1 = 32'h3FC00000; b2.x2 = 32'h40000000; b2.in_valid = 1;
        b4.x1 = 32'h3FC00000; b4.x2 = 32'h40000000; b4.in_valid = 1;
        bd.x1 = 64'h3FF8000000000000; bd.x2 = 64'h4000000000000000; bd.in_valid = 1;
        tick();
        bm.in_valid = 0; b1.in_valid = 0; b2.in_valid = 0; b4.in_valid = 0; bd.in_valid = 0;
        lm = 0; l1 = 0; l2 = 0; l4 = 0; ld = 0;
        ym = '0; y1 = '0; y2 = '0; y4 = '0; yd = '0;
        for (int c = 1; c <= 6; c++) begin
            if (bm.out_valid && lm == 0) begin lm = c; ym = bm.y; end
            if (b1.out_valid && l1 == 0) begin l1 = c; y1 = b1.y; end
            if (b2.out_valid && l2 == 0) begin l2 = c; y2 = b2.y; end
            if (b4.out_valid && l4 == 0) begin l4 = c; y4 = b4.y; end
            if (bd.out_valid && ld == 0) begin ld = c; yd = bd.y; end
            tick();
        end
        chk("lat S3",  64'(lm), 64'd3);
        chk("y S3",    64'(ym), 64'h40400000);
        chk("lat S1",  64'(l1), 64'd1);
        chk("y S1",    64'(y1), 64'h40400000);
        chk("lat S2",  64'(l2), 64'd2);
        chk("y S2",    64'(y2), 64'h40400000);
        chk("lat S4",  64'(l4), 64'd4);
        chk("y S4",    64'(y4), 64'h40400000);
        chk("lat f64", 64'(ld), 64'd3);
        chk("y f64",   yd,      64'h4008000000000000);

        op("basic",     32'h3FC00000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        op("rne",       32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 3'b000);
        op("trunc",     32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 3'b000);
        op("ovf",       32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 3'b010);
        op("udf",       32'h00800000, 32'h3F000000, 1'b0, 32'h00000000, 3'b001);
        op("inf*zero",  32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 3'b100);
        op("-inf*2",    32'hFF800000, 32'h40000000, 1'b0, 32'hFF800000, 3'b000);
        op("nan",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100);
        op("-0*3",      32'h80000000, 32'h40400000, 1'b0, 32'h80000000, 3'b000);
        op("subn flush",32'h00400000, 32'h7F000000, 1'b0, 32'h00000000, 3'b000);

        // Six back-to-back operands, consumer stalls cycles 4..7
        sent = 0; rcv = 0;
        for (int c = 0; c < 30; c++) begin
            bm.in_valid  = (sent < 6);
            bm.x1        = tab[(sent < 6) ? sent : 0];
            bm.x2        = 32'h40000000;
            bm.rm        = 1'b0;
            bm.out_ready = !(c >= 4 && c <= 7);
            #1;
            if (c < 10)
                chk($sformatf("bp in_ready c%0d", c), 64'(bm.in_ready), 64'(!(c >= 4 && c <= 7)));
            if (bm.out_valid) begin
                if (rcv < 6) chk($sformatf("bp y c%0d", c), 64'(bm.y), 64'(expv[rcv]));
                else         chk("bp extra result", 64'(bm.out_valid), 64'd0);
                if (bm.out_ready) rcv++;
            end
            if (bm.in_valid && bm.in_ready) sent++;
            tick();
        end
        chk("bp sent", 64'(sent), 64'd6);
        chk("bp rcvd", 64'(rcv),  64'd6);

        // Reset with three results in flight
        bm.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bm.x1 = tab[i]; bm.x2 = 32'h40000000; bm.in_valid = 1'b1;
            tick();
        end
        bm.in_valid = 1'b0; bm.out_ready = 1'b0; rst = 1'b1;
        tick();
        chk("mid rst out_valid", 64'(bm.out_valid), 64'd0);
        chk("mid rst y",         64'(bm.y),         64'd0);
        chk("mid rst flags",     64'(bm.flags),     64'd0);
        chk("mid rst in_ready",  64'(bm.in_ready),  64'd1);
        rst = 1'b0; bm.out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bm.out_valid) seen = 1'b1;
            tick();
        end
        chk("no stale after rst", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
